// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clock_divider_pkg;

    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // Number of high cycles in one square-wave period, ceil(d/2); 32-bit so d=2^N-1 cannot overflow.
    function automatic int unsigned square_high_count(input int unsigned d);
        return (d + 1) >> 1;
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: period counter, shadowed divisor and registered clock/tick outputs.
module clock_divider_channel
    import clock_divider_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clock_in,
    input  logic         reset,
    input  logic         sync,
    input  logic         enable,
    input  logic         mode,
    input  logic [N-1:0] divisor,
    output logic         clock_out,
    output logic         tick
);

    logic [N-1:0] c_q, c_d;
    logic [N-1:0] d_q, d_d;
    logic         clock_out_q, clock_out_d;
    logic         tick_q, tick_d;
    logic         terminal;
    logic         square_level;

    // D of 0 or 1 always reloads; an out-of-range count is treated as the end of the period.
    always_comb begin
        terminal     = (d_q < N'(2)) || (c_q >= d_q - N'(1));
        square_level = 32'(c_q) < square_high_count(32'(d_q));
        tick_d       = enable && (d_q != '0) && (c_q == '0);

        clock_out_d = clock_out_q;
        if (enable) begin
            clock_out_d = (mode == MODE_PULSE) ? tick_d : square_level;
        end

        c_d = c_q;
        d_d = d_q;
        if (sync) begin
            c_d = '0;
            d_d = divisor;
        end else if (enable) begin
            if (terminal) begin
                c_d = '0;
                d_d = divisor;
            end else begin
                c_d = c_q + N'(1);
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            c_q         <= '0;
            d_q         <= divisor;
            clock_out_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            c_q         <= c_d;
            d_q         <= d_d;
            clock_out_q <= clock_out_d;
            tick_q      <= tick_d;
        end
    end

    assign clock_out = clock_out_q;
    assign tick      = tick_q;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider sharing one clock, reset and phase sync.
module clock_divider_multi
    import clock_divider_pkg::*;
#(
    parameter int N        = 8,
    parameter int CHANNELS = 4
) (
    input  logic                  clock_in,
    input  logic                  reset,
    input  logic                  sync,
    input  logic [CHANNELS-1:0]   enable,
    input  logic [CHANNELS-1:0]   mode,
    input  logic [CHANNELS*N-1:0] divisor,
    output logic [CHANNELS-1:0]   clock_out,
    output logic [CHANNELS-1:0]   tick
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        clock_divider_channel #(
            .N(N)
        ) u_channel (
            .clock_in (clock_in),
            .reset    (reset),
            .sync     (sync),
            .enable   (enable[i]),
            .mode     (mode[i]),
            .divisor  (divisor[i*N +: N]),
            .clock_out(clock_out[i]),
            .tick     (tick[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi: a behavioural model queues expected outputs each cycle.
module tb_clock_divider_multi;

    localparam int N  = 8;
    localparam int CH = 4;

    logic              clock_in = 1'b0;
    logic              reset;
    logic              sync;
    logic [CH-1:0]     enable;
    logic [CH-1:0]     mode;
    logic [CH*N-1:0]   divisor;
    logic [CH-1:0]     clock_out;
    logic [CH-1:0]     tick;

    typedef struct packed {
        logic [CH-1:0] clk;
        logic [CH-1:0] tck;
    } exp_t;

    exp_t          sb_q[$];
    int            vectors     = 0;
    int            miscompares = 0;
    int            m_c[CH];
    int            m_d[CH];
    logic [CH-1:0] m_clk = '0;

    clock_divider_multi #(
        .N(N),
        .CHANNELS(CH)
    ) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .sync     (sync),
        .enable   (enable),
        .mode     (mode),
        .divisor  (divisor),
        .clock_out(clock_out),
        .tick     (tick)
    );

    always #5 clock_in = ~clock_in;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] timeout");
    end

    task automatic set_div(input int i, input int v);
        divisor[i*N +: N] = N'(v);
    endtask

    // Advances the reference model by one clock using the inputs as driven, then clocks the DUT.
    task automatic drive_cycle();
        exp_t e;
        int   dv;
        logic t;
        logic c;
        for (int i = 0; i < CH; i++) begin
            dv = int'(divisor[i*N +: N]);
            t  = enable[i] && (m_d[i] != 0) && (m_c[i] == 0);
            if (!enable[i])   c = m_clk[i];
            else if (mode[i]) c = t;
            else              c = (m_c[i] < (m_d[i] + 1) / 2);
            if (reset) begin
                m_c[i] = 0; m_d[i] = dv; c = 1'b0; t = 1'b0;
            end else if (sync) begin
                m_c[i] = 0; m_d[i] = dv;
            end else if (enable[i]) begin
                if (m_d[i] <= 1 || m_c[i] >= m_d[i] - 1) begin
                    m_c[i] = 0; m_d[i] = dv;
                end else begin
                    m_c[i] = m_c[i] + 1;
                end
            end
            m_clk[i] = c;
            e.clk[i] = c;
            e.tck[i] = t;
        end
        sb_q.push_back(e);
        @(posedge clock_in);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        int   j;
        enable = '1; mode = '0; sync = 1'b0;
        for (int i = 0; i < CH; i++) set_div(i, 4);
        for (int k = 0; k < 14; k++) begin
            reset = (k < 2);
            drive_cycle();
            e = sb_q.pop_front();
            vectors += 2;
            if (clock_out !== e.clk) begin miscompares++; $display("[TB] FAIL reset clk cyc %0d got %b want %b", k, clock_out, e.clk); end
            if (tick !== e.tck)      begin miscompares++; $display("[TB] FAIL reset tick cyc %0d got %b want %b", k, tick, e.tck); end
            if (k >= 2) begin
                j = k - 2;
                vectors += 2;
                if (clock_out[0] !== ((j % 4) < 2)) begin miscompares++; $display("[TB] FAIL reset 1100 cyc %0d got %b want %b", k, clock_out[0], ((j % 4) < 2)); end
                if (tick[0] !== ((j % 4) == 0))     begin miscompares++; $display("[TB] FAIL reset tick4 cyc %0d got %b want %b", k, tick[0], ((j % 4) == 0)); end
            end
        end
    endtask

    task automatic test_independent();
        exp_t e;
        int   j;
        enable = '1; mode = 4'b0010; sync = 1'b0;
        set_div(0, 5); set_div(1, 3); set_div(2, 7); set_div(3, 2);
        for (int k = 0; k < 17; k++) begin
            reset = (k < 1);
            drive_cycle();
            e = sb_q.pop_front();
            vectors += 2;
            if (clock_out !== e.clk) begin miscompares++; $display("[TB] FAIL indep clk cyc %0d got %b want %b", k, clock_out, e.clk); end
            if (tick !== e.tck)      begin miscompares++; $display("[TB] FAIL indep tick cyc %0d got %b want %b", k, tick, e.tck); end
            if (k >= 1) begin
                j = k - 1;
                vectors += 2;
                if (clock_out[0] !== ((j % 5) < 3)) begin miscompares++; $display("[TB] FAIL indep 11100 cyc %0d got %b want %b", k, clock_out[0], ((j % 5) < 3)); end
                if (clock_out[1] !== ((j % 3) == 0) || tick[1] !== ((j % 3) == 0)) begin
                    miscompares++; $display("[TB] FAIL indep pulse100 cyc %0d got %b/%b want %b", k, clock_out[1], tick[1], ((j % 3) == 0));
                end
            end
        end
    endtask

    task automatic test_divisor_change();
        exp_t e;
        int   j;
        logic want;
        enable = '1; mode = '0; sync = 1'b0;
        for (int i = 0; i < CH; i++) set_div(i, 4);
        for (int k = 0; k < 18; k++) begin
            reset = (k < 1);
            if (k == 2) set_div(0, 6);
            drive_cycle();
            e = sb_q.pop_front();
            vectors += 2;
            if (clock_out !== e.clk) begin miscompares++; $display("[TB] FAIL divchg clk cyc %0d got %b want %b", k, clock_out, e.clk); end
            if (tick !== e.tck)      begin miscompares++; $display("[TB] FAIL divchg tick cyc %0d got %b want %b", k, tick, e.tck); end
            if (k >= 1) begin
                j    = k - 1;
                want = (j < 4) ? (j < 2) : (((j - 4) % 6) < 3);
                vectors++;
                if (clock_out[0] !== want) begin miscompares++; $display("[TB] FAIL divchg shape cyc %0d got %b want %b", k, clock_out[0], want); end
            end
        end
    endtask

    task automatic test_enable_gap();
        exp_t e;
        enable = '1; mode = '0; sync = 1'b0;
        for (int i = 0; i < CH; i++) set_div(i, 8);
        for (int k = 0; k < 21; k++) begin
            reset     = (k < 1);
            enable[0] = !(k >= 3 && k < 6);
            drive_cycle();
            e = sb_q.pop_front();
            vectors += 2;
            if (clock_out !== e.clk) begin miscompares++; $display("[TB] FAIL engap clk cyc %0d got %b want %b", k, clock_out, e.clk); end
            if (tick !== e.tck)      begin miscompares++; $display("[TB] FAIL engap tick cyc %0d got %b want %b", k, tick, e.tck); end
            if (k >= 3 && k < 6) begin
                vectors++;
                if (clock_out[0] !== 1'b1 || tick[0] !== 1'b0) begin
                    miscompares++; $display("[TB] FAIL engap hold cyc %0d got %b/%b want 1/0", k, clock_out[0], tick[0]);
                end
            end
            if (k == 12) begin
                vectors++;
                if (tick[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL engap period11 got %b want 1", tick[0]); end
            end
        end
        enable = '1;
    endtask

    task automatic test_sync();
        exp_t e;
        enable = '1; mode = '0;
        set_div(0, 3); set_div(1, 5); set_div(2, 6); set_div(3, 7);
        for (int k = 0; k < 26; k++) begin
            reset = (k < 1) || (k == 20);
            sync  = (k == 10) || (k == 20);
            drive_cycle();
            e = sb_q.pop_front();
            vectors += 2;
            if (clock_out !== e.clk) begin miscompares++; $display("[TB] FAIL sync clk cyc %0d got %b want %b", k, clock_out, e.clk); end
            if (tick !== e.tck)      begin miscompares++; $display("[TB] FAIL sync tick cyc %0d got %b want %b", k, tick, e.tck); end
            if (k == 11 || k == 21) begin
                vectors++;
                if (tick !== 4'hF) begin miscompares++; $display("[TB] FAIL sync align cyc %0d got %b want 1111", k, tick); end
            end
            if (k == 20) begin
                vectors++;
                if (clock_out !== 4'h0 || tick !== 4'h0) begin
                    miscompares++; $display("[TB] FAIL sync resetprio got %b/%b want 0000/0000", clock_out, tick);
                end
            end
        end
        sync = 1'b0;
    endtask

    task automatic test_div_zero_one();
        exp_t e;
        int   v;
        enable = '1; mode = 4'b0010; sync = 1'b0;
        set_div(2, 4); set_div(3, 9);
        for (int k = 0; k < 21; k++) begin
            reset = (k < 1);
            v     = (k < 6) ? 0 : ((k < 12) ? 1 : 2);
            set_div(0, v); set_div(1, v);
            drive_cycle();
            e = sb_q.pop_front();
            vectors += 2;
            if (clock_out !== e.clk) begin miscompares++; $display("[TB] FAIL div01 clk cyc %0d got %b want %b", k, clock_out, e.clk); end
            if (tick !== e.tck)      begin miscompares++; $display("[TB] FAIL div01 tick cyc %0d got %b want %b", k, tick, e.tck); end
            if (k >= 1 && k <= 6) begin
                vectors++;
                if (clock_out[1:0] !== 2'b00 || tick[1:0] !== 2'b00) begin
                    miscompares++; $display("[TB] FAIL div01 stopped cyc %0d got %b/%b want 00/00", k, clock_out[1:0], tick[1:0]);
                end
            end
            if (k >= 7 && k <= 12) begin
                vectors++;
                if (clock_out[1:0] !== 2'b11 || tick[1:0] !== 2'b11) begin
                    miscompares++; $display("[TB] FAIL div01 rate1 cyc %0d got %b/%b want 11/11", k, clock_out[1:0], tick[1:0]);
                end
            end
            if (k >= 13) begin
                vectors++;
                if (clock_out[0] !== (((k - 13) % 2) == 0)) begin
                    miscompares++; $display("[TB] FAIL div01 rate2 cyc %0d got %b want %b", k, clock_out[0], (((k - 13) % 2) == 0));
                end
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        sync    = 1'b0;
        enable  = '0;
        mode    = '0;
        divisor = '0;
        for (int i = 0; i < CH; i++) begin
            m_c[i] = 0;
            m_d[i] = 0;
        end
        @(posedge clock_in);
        #1;
        test_reset();
        test_independent();
        test_divisor_change();
        test_enable_gap();
        test_sync();
        test_div_zero_one();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- Multi-channel programmable clock divider. It generates CHANNELS independent divided-clock enables from one input clock.
- Each channel has:
  - its own run-time divisor, with a glitch-free shadow update at the period boundary;
  - a per-channel output mode (square wave or single-cycle pulse);
  - a period-start tick strobe.
- A global sync input phase-aligns all channels. Outputs feed downstream logic as clock enables or LED/strobe timing.

Parameters:
- N, 8, divisor/counter width in bits; maximum divisor 2^N-1.
- CHANNELS, 4, number of independent divider channels.

Ports:
- clock_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous reset, active-high.
- sync  input  1  global phase restart for all channels.
- enable  input  CHANNELS  per-channel run enable; bit i controls channel i.
- mode  input  CHANNELS  per-channel mode; 0 = square, 1 = pulse.
- divisor  input  CHANNELS*N  flattened divisors; channel i uses bits [i*N+N-1 : i*N].
- clock_out  output  CHANNELS  divided output per channel, registered.
- tick  output  CHANNELS  one-cycle strobe at the start of each output period, registered.

Behaviour:
- Priority per channel: reset > sync > enable.
- Per-channel state:
  - counter C, N bits;
  - active divisor D, N bits. D is the shadow copy; the live divisor input is never used mid-period.
- Reset (synchronous, active-high):
  - C=0 and D=divisor[i].
  - clock_out=0 and tick=0 for all channels.
- Sync high: every channel sets C=0 and D=divisor[i] in the same cycle. The following cycles behave as if a new period starts at C=0. clock_out and tick are computed from the pre-update state as usual.
- Enable low: C and D are frozen, clock_out holds its value, tick=0.
- Enable high, D>=2:
  - If C==D-1 (terminal), C becomes 0 and D loads divisor[i]. The new divisor takes effect at the next period.
  - Otherwise C increments by 1.
  - Compare D-1 in N bits, evaluated only when D>=1.
  - If C>=D (possible only transiently), treat it as terminal.
- Outputs are registered, 1-cycle latency: the value in cycle t+1 is a function of C, D and mode in cycle t.
  - tick = enable & (D!=0) & (C==0).
  - Square mode: clock_out = (C < (D+1)>>1). High lasts ceil(D/2) cycles, low lasts floor(D/2).
    - D=4 gives 1100.
    - D=5 gives 11100.
  - Pulse mode: clock_out = tick.
- D==0: channel stopped. C is held at 0; clock_out=0 and tick=0. D still reloads from divisor[i] every enabled cycle, so the channel restarts without needing a reset.
- D==1: C stays 0, tick=1 every enabled cycle, clock_out=1 in both modes. Full-rate toggling is not produced.
- Changing mode mid-period affects the next registered output immediately; no resync.
- Channels are fully independent except for the shared reset and sync.

Decomposition:
- Package clock_divider_pkg holds:
  - MODE_SQUARE=1'b0 and MODE_PULSE=1'b1;
  - a function for the square-wave high count, (d+1)>>1.
- Sub-module clock_divider_channel holds one channel's C, D and output registers, parameterised by N.
- The top instantiates CHANNELS copies in a generate loop and slices the divisor bus.

Test Plan:
- Reset with divisor=4 on all channels -> clock_out=0 and tick=0 during reset. First cycle after release: clock_out=1 and tick=1. Then clock_out shows 1100 repeating and tick pulses every 4 cycles.
- Channel 0 divisor 5, square mode; channel 1 divisor 3, pulse mode -> ch0 shows 11100 repeating; ch1 clock_out=tick=100 repeating. Channels are independent.
- Divisor changes 4->6 at C=1 -> the current period completes as 4 cycles. The next period shows 111000, with tick at the boundary. No truncated or extended pulse.
- Enable dropped for 3 cycles at C=2 (D=8) -> clock_out holds and tick=0 during the gap. Counting resumes from C=2 and total period length is 8+3 cycles.
- Channels at differing phases, then sync pulsed for one cycle -> all channels issue tick together 2 cycles after sync rises. Afterwards patterns are aligned; reset asserted with sync has reset precedence.
- Divisor 0 then 1 -> with D=0, clock_out=0 and tick=0 with C held. Writing 1 gives clock_out=1 and tick=1 every cycle. Writing 2 then gives 10 repeating.
